frame_write_scheduler: RTL and testbench

FRAME_WRITE_SCHEDULER -- requirements
Module: frame_write_scheduler

---
 rtl/frame_write_scheduler_pkg.sv | 9 +
 rtl/fb_clear_counter.sv | 19 +
 rtl/frame_write_scheduler.sv | 103 ++++++++++
 tb/tb_frame_write_scheduler.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/frame_write_scheduler_pkg.sv
// frame_write_scheduler_pkg: shared display states, screen defaults and helpers
package frame_write_scheduler_pkg;
  typedef enum logic [1:0] {CLEAR, PLOT, DRAIN, SWAP} fws_state_e;
  localparam int DEF_SCREEN_WIDTH = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic hit);
    return v + 8'(hit && v != 8'hff);
  endfunction
endpackage

// File: rtl/fb_clear_counter.sv
// fb_clear_counter: clear address generator, counts up to LAST and holds there until start
module fb_clear_counter #(
  parameter int ADDR_WIDTH = 19,
  parameter int LAST = 307199
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST);
  logic [ADDR_WIDTH-1:0] addr_q;
  always_ff @(posedge clk)
    if (!resetn || start) addr_q <= '0;
    else if (!last) addr_q <= addr_q + 1'b1;
  assign addr = addr_q;
  assign last = addr_q == LAST_A;
endmodule

// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: clears the back buffer, passes plotter writes through, swaps banks on vsync
module frame_write_scheduler
  import frame_write_scheduler_pkg::*;
#(
  parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int ADDR_WIDTH = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  vsync,
  input  logic [ADDR_WIDTH-1:0] plot_addr,
  input  logic                  plot_data,
  input  logic                  plot_wr_en,
  input  logic                  plot_busy,
  output logic                  plotter_enable,
  output logic                  plotter_restart,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_data,
  output logic                  fb_wr_en,
  output logic                  fb_bank,
  output logic                  disp_bank,
  output logic [7:0]            overrun_count,
  output logic [7:0]            drop_count
);
  fws_state_e state_q, state_d;
  logic vs_q, en_q, en_d, rst_q, rst_d, wr_q, wr_d, data_q, data_d;
  logic fb_bank_q, disp_q, disp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, clr_addr;
  logic [7:0] ovr_q, ovr_d, drop_q, drop_d;
  logic clr_last, vs_edge;
  assign vs_edge = vsync & ~vs_q;
  fb_clear_counter #(.ADDR_WIDTH(ADDR_WIDTH), .LAST(SCREEN_WIDTH * SCREEN_HEIGHT - 1)) u_clr (
    .clk(clk), .resetn(resetn), .start(state_q == SWAP), .addr(clr_addr), .last(clr_last)
  );
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    rst_d = 1'b0;
    disp_d = disp_q;
    addr_d = plot_addr;
    data_d = plot_data;
    wr_d = plot_wr_en;
    case (state_q)
      CLEAR: begin
        addr_d = clr_addr;
        data_d = 1'b0;
        wr_d = 1'b1;
        if (clr_last) state_d = PLOT;
      end
      PLOT: begin
        en_d = ~vs_edge;
        if (vs_edge) state_d = DRAIN;
      end
      DRAIN: if (!plot_busy && !plot_wr_en) state_d = SWAP;
      default: begin
        addr_d = '0;
        data_d = 1'b0;
        wr_d = 1'b0;
        rst_d = 1'b1;
        disp_d = ~disp_q;
        state_d = CLEAR;
      end
    endcase
    ovr_d = sat_inc(ovr_q, vs_edge && state_q != PLOT);
    drop_d = sat_inc(drop_q, plot_wr_en && (state_q == CLEAR || state_q == SWAP));
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q <= CLEAR;
      vs_q <= 1'b0;
      en_q <= 1'b0;
      rst_q <= 1'b0;
      addr_q <= '0;
      data_q <= 1'b0;
      wr_q <= 1'b0;
      disp_q <= 1'b0;
      fb_bank_q <= 1'b1;
      ovr_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= vsync;
      en_q <= en_d;
      rst_q <= rst_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      disp_q <= disp_d;
      fb_bank_q <= ~disp_d;
      ovr_q <= ovr_d;
      drop_q <= drop_d;
    end
  assign plotter_enable = en_q;
  assign plotter_restart = rst_q;
  assign fb_addr = addr_q;
  assign fb_data = data_q;
  assign fb_wr_en = wr_q;
  assign fb_bank = fb_bank_q;
  assign disp_bank = disp_q;
  assign overrun_count = ovr_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_frame_write_scheduler.sv
// tb_frame_write_scheduler: directed + randomized checks against a behavioural frame model
module tb_frame_write_scheduler;
  localparam int W = 8, H = 4, N = W * H, AW = 5;
  logic clk = 1'b0, resetn = 1'b0, vsync = 1'b0, plot_data = 1'b0, plot_wr_en = 1'b0, plot_busy = 1'b0;
  logic [AW-1:0] plot_addr = '0;
  logic plotter_enable, plotter_restart, fb_data, fb_wr_en, fb_bank, disp_bank;
  logic [AW-1:0] fb_addr;
  logic [7:0] overrun_count, drop_count;
  int pass_cnt = 0, total_cnt = 0;
  bit chk_on = 1'b0;

  frame_write_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .vsync(vsync), .plot_addr(plot_addr), .plot_data(plot_data),
    .plot_wr_en(plot_wr_en), .plot_busy(plot_busy), .plotter_enable(plotter_enable),
    .plotter_restart(plotter_restart), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wr_en(fb_wr_en),
    .fb_bank(fb_bank), .disp_bank(disp_bank), .overrun_count(overrun_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: phase 0=clearing, 1=plotting, 2=draining, 3=swapping
  int phase = 0, clr_idx = 0, m_ovr = 0, m_drop = 0;
  bit prev_vs = 0, m_disp = 0, m_en = 0, m_restart = 0, m_wr = 0, m_data = 0;
  int m_addr = 0;
  always @(posedge clk) begin
    if (!resetn) begin
      phase = 0; clr_idx = 0; m_ovr = 0; m_drop = 0; prev_vs = 0; m_disp = 0;
      m_en = 0; m_restart = 0; m_wr = 0; m_data = 0; m_addr = 0;
    end else begin
      bit edge_seen;
      edge_seen = vsync && !prev_vs;
      prev_vs = vsync;
      if (edge_seen && phase != 1 && m_ovr < 255) m_ovr++;
      if (plot_wr_en && (phase == 0 || phase == 3) && m_drop < 255) m_drop++;
      m_en = 0; m_restart = 0;
      m_wr = plot_wr_en; m_addr = int'(plot_addr); m_data = plot_data;
      if (phase == 0) begin
        m_wr = 1; m_addr = clr_idx; m_data = 0;
        if (clr_idx == N - 1) phase = 1; else clr_idx++;
      end else if (phase == 1) begin
        m_en = !edge_seen;
        if (edge_seen) phase = 2;
      end else if (phase == 2) begin
        if (!plot_busy && !plot_wr_en) phase = 3;
      end else begin
        m_wr = 0; m_addr = 0; m_data = 0; m_restart = 1; m_disp = !m_disp;
        phase = 0; clr_idx = 0;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    check("fb_wr_en", fb_wr_en, m_wr);
    if (m_wr) begin
      check("fb_addr", fb_addr, m_addr);
      check("fb_data", fb_data, m_data);
    end
    check("plotter_enable", plotter_enable, m_en);
    check("plotter_restart", plotter_restart, m_restart);
    check("disp_bank", disp_bank, m_disp);
    check("fb_bank", fb_bank, !m_disp);
    check("overrun_count", overrun_count, m_ovr);
    check("drop_count", drop_count, m_drop);
  end

  task automatic wait_for_enable(input string name);
    int k;
    for (k = 0; k < 100 && !plotter_enable; k++) @(negedge clk);
    check({name, "_timeout"}, k < 100, 1);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_wr_en", fb_wr_en, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_fb_bank", fb_bank, 1);
    check("rst_enable", plotter_enable, 0);
    check("rst_counts", {overrun_count, drop_count}, 0);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("clr_seq_addr", fb_addr, i);
      check("clr_seq_wr", {fb_wr_en, fb_data, fb_bank}, 3'b101);
      plot_wr_en = (i == 3); plot_addr = 5'd7; plot_data = 1'b1;
      vsync = (i == 10);
    end
    plot_wr_en = 1'b0;
    @(negedge clk);
    check("enable_after_clear", plotter_enable, 1);
    check("drop_one", drop_count, 1);
    check("overrun_one", overrun_count, 1);
    plot_addr = 5'd5; plot_data = 1'b1; plot_wr_en = 1'b1;
    @(negedge clk);
    plot_wr_en = 1'b0; plot_data = 1'b0;
    check("plot_pass", {fb_wr_en, fb_data, 27'd0, fb_addr}, {1'b1, 1'b1, 27'd0, 5'd5});
    vsync = 1'b1; plot_busy = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    check("enable_dropped", plotter_enable, 0);
    @(negedge clk);
    plot_busy = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = plotter_restart;
    end
    check("restart_seen", found, 1);
    check("swap_banks", {disp_bank, fb_bank}, 2'b10);
    @(negedge clk);
    check("clear_resume", {fb_wr_en, 27'd0, fb_addr}, {1'b1, 27'd0, 5'd0});
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = fb_wr_en && fb_addr == 5'd20 && !plotter_enable;
    end
    check("reach_addr20", found, 1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check("reset_mid_bank", {disp_bank, fb_bank}, 2'b01);
    check("reset_mid_counts", {overrun_count, drop_count}, 0);
    @(negedge clk);
    check("reset_mid_restart", {fb_wr_en, 27'd0, fb_addr}, {1'b1, 27'd0, 5'd0});
    wait_for_enable("sat_enter");
    plot_busy = 1'b1;
    for (int k = 0; k < 602; k++) begin
      vsync = ~vsync;
      @(negedge clk);
    end
    vsync = 1'b0;
    @(negedge clk);
    check("overrun_saturated", overrun_count, 255);
    plot_busy = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      vsync = ($urandom_range(0, 19) == 0);
      plot_wr_en = $urandom_range(0, 1) == 1;
      plot_addr = AW'($urandom);
      plot_data = $urandom_range(0, 1) == 1;
      plot_busy = ($urandom_range(0, 2) == 0);
      resetn = ($urandom_range(0, 699) != 0);
      @(negedge clk);
    end
    resetn = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
